// File: rtl/cu_pkg.sv
// Shared types and encodings for the multicycle MIPS control unit.
package cu_pkg;

    // FSM states; the encoding is visible on state_dbg.
    typedef enum logic [3:0] {
        StReset  = 4'd0,
        StFetch  = 4'd1,
        StDecode = 4'd2,
        StExecR  = 4'd3,
        StWbR    = 4'd4,
        StExecI  = 4'd5,
        StWbI    = 4'd6,
        StAddr   = 4'd7,
        StMemRd  = 4'd8,
        StWbMem  = 4'd9,
        StMemWr  = 4'd10,
        StBranch = 4'd11,
        StJump   = 4'd12,
        StExcp   = 4'd13
    } state_e;

    // Opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type function codes (instr[5:0])
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    // ALU operation encodings
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // ALU B-operand select
    localparam logic [1:0] ALUSRCB_B       = 2'b00;
    localparam logic [1:0] ALUSRCB_FOUR    = 2'b01;
    localparam logic [1:0] ALUSRCB_IMM     = 2'b10;
    localparam logic [1:0] ALUSRCB_IMM_SH2 = 2'b11;

    // PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_EXCP   = 2'b11;

    // Returns {valid, alu_op}; an unknown funct reports invalid and presents ALU_ADD.
    function automatic logic [3:0] funct_decode(input logic [5:0] funct);
        unique case (funct)
            FN_ADD:  funct_decode = {1'b1, ALU_ADD};
            FN_SUB:  funct_decode = {1'b1, ALU_SUB};
            FN_AND:  funct_decode = {1'b1, ALU_AND};
            FN_OR:   funct_decode = {1'b1, ALU_OR};
            FN_SLT:  funct_decode = {1'b1, ALU_SLT};
            default: funct_decode = {1'b0, ALU_ADD};
        endcase
    endfunction

endpackage

// File: rtl/cu_wait_counter.sv
// Wait-state counter: done once MAX_COUNT extra cycles have elapsed since the last clear.
module cu_wait_counter #(
    parameter int unsigned MAX_COUNT = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic done
);

    // At least one bit so MAX_COUNT = 0 still elaborates; done is then permanently high.
    localparam int unsigned W = (MAX_COUNT > 0) ? $clog2(MAX_COUNT + 1) : 1;

    logic [W-1:0] cnt_q;

    assign done = (cnt_q == W'(MAX_COUNT));

    // Count up while enabled, saturating at MAX_COUNT; clear has priority.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (enable && !done) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

endmodule

// File: rtl/control_unit.sv
// Multicycle MIPS control FSM: Moore outputs per state, plus the branch pc_write term.
module control_unit
    import cu_pkg::*;
#(
    parameter int unsigned MEM_WAIT_CYCLES = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       overflow,
    output logic       pc_write,
    output logic       i_or_d,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic       mem_to_reg,
    output logic       reg_dest,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_op,
    output logic [1:0] pc_source,
    output logic [3:0] state_dbg
);

    state_e     state_q, state_d;
    logic       wait_en, wait_clr, wait_done;
    logic [3:0] fn_dec;
    logic       fn_valid;
    logic [2:0] fn_alu;
    logic       r_ov_trap;

    assign fn_dec    = funct_decode(funct);
    assign fn_valid  = fn_dec[3];
    assign fn_alu    = fn_dec[2:0];
    // Only ADD and SUB can raise an arithmetic overflow trap.
    assign r_ov_trap = overflow && ((funct == FN_ADD) || (funct == FN_SUB));

    // Counter restarts on every state change so each wait state counts from zero.
    assign wait_clr  = (state_d != state_q);

    cu_wait_counter #(
        .MAX_COUNT(MEM_WAIT_CYCLES)
    ) u_wait_counter (
        .clk    (clk),
        .reset  (reset),
        .clear  (wait_clr),
        .enable (wait_en),
        .done   (wait_done)
    );

    // State register; reset low forces RESET immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StReset;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_dbg = state_q;

    // Next-state and output decode; every output defaults to 0.
    always_comb begin
        state_d    = state_q;
        wait_en    = 1'b0;
        pc_write   = 1'b0;
        i_or_d     = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        reg_dest   = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = ALUSRCB_B;
        alu_op     = ALU_AND;
        pc_source  = PCSRC_ALU;

        unique case (state_q)
            StReset: begin
                state_d = StFetch;
            end
            StFetch: begin
                alu_src_b = ALUSRCB_FOUR;
                alu_op    = ALU_ADD;
                wait_en   = 1'b1;
                if (wait_done) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = StDecode;
                end
            end
            StDecode: begin
                // Branch target computed speculatively into ALUout.
                alu_src_b = ALUSRCB_IMM_SH2;
                alu_op    = ALU_ADD;
                unique case (opcode)
                    OP_RTYPE:     state_d = StExecR;
                    OP_ADDI:      state_d = StExecI;
                    OP_LW, OP_SW: state_d = StAddr;
                    OP_BEQ, OP_BNE: state_d = StBranch;
                    OP_J:         state_d = StJump;
                    default:      state_d = StExcp;
                endcase
            end
            StExecR: begin
                alu_src_a = 1'b1;
                alu_src_b = ALUSRCB_B;
                alu_op    = fn_alu;
                state_d   = fn_valid ? StWbR : StExcp;
            end
            StWbR: begin
                reg_dest  = 1'b1;
                reg_write = !r_ov_trap;
                state_d   = r_ov_trap ? StExcp : StFetch;
            end
            StExecI: begin
                alu_src_a = 1'b1;
                alu_src_b = ALUSRCB_IMM;
                alu_op    = ALU_ADD;
                state_d   = StWbI;
            end
            StWbI: begin
                reg_write = !overflow;
                state_d   = overflow ? StExcp : StFetch;
            end
            StAddr: begin
                alu_src_a = 1'b1;
                alu_src_b = ALUSRCB_IMM;
                alu_op    = ALU_ADD;
                state_d   = (opcode == OP_LW) ? StMemRd : StMemWr;
            end
            StMemRd: begin
                i_or_d  = 1'b1;
                wait_en = 1'b1;
                if (wait_done) begin
                    state_d = StWbMem;
                end
            end
            StWbMem: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                state_d    = StFetch;
            end
            StMemWr: begin
                i_or_d    = 1'b1;
                mem_write = 1'b1;
                state_d   = StFetch;
            end
            StBranch: begin
                alu_src_a = 1'b1;
                alu_src_b = ALUSRCB_B;
                alu_op    = ALU_SUB;
                pc_source = PCSRC_ALUOUT;
                pc_write  = (opcode == OP_BNE) ? !zero : zero;
                state_d   = StFetch;
            end
            StJump: begin
                pc_source = PCSRC_JUMP;
                pc_write  = 1'b1;
                state_d   = StFetch;
            end
            StExcp: begin
                pc_source = PCSRC_EXCP;
                pc_write  = 1'b1;
                state_d   = StFetch;
            end
            default: begin
                state_d = StReset;
            end
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: per-instruction expected cycle sequences, two wait settings.
module tb_control_unit;
    import cu_pkg::*;

    typedef struct packed {
        logic       pc_write;
        logic       i_or_d;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic       mem_to_reg;
        logic       reg_dest;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic [1:0] pc_source;
        logic [3:0] st;
    } ctl_t;

    typedef struct {
        bit    sel;
        int    cyc;
        string name;
        ctl_t  exp;
    } entry_t;

    logic       clk = 1'b0;
    logic       rst1, rst0;
    logic [5:0] opcode, funct;
    logic       zero, overflow;

    logic       pc_write_1, i_or_d_1, mem_write_1, ir_write_1, reg_write_1;
    logic       mem_to_reg_1, reg_dest_1, alu_src_a_1;
    logic [1:0] alu_src_b_1, pc_source_1;
    logic [2:0] alu_op_1;
    logic [3:0] state_dbg_1;
    logic       pc_write_0, i_or_d_0, mem_write_0, ir_write_0, reg_write_0;
    logic       mem_to_reg_0, reg_dest_0, alu_src_a_0;
    logic [1:0] alu_src_b_0, pc_source_0;
    logic [2:0] alu_op_0;
    logic [3:0] state_dbg_0;

    ctl_t   act1, act0;
    entry_t exp_q[$];
    ctl_t   obs[0:31];
    int     errors = 0;
    int     checks = 0;

    always #5 clk = ~clk;

    control_unit #(.MEM_WAIT_CYCLES(1)) u_dut1 (
        .clk(clk), .reset(rst1), .opcode(opcode), .funct(funct), .zero(zero),
        .overflow(overflow), .pc_write(pc_write_1), .i_or_d(i_or_d_1),
        .mem_write(mem_write_1), .ir_write(ir_write_1), .reg_write(reg_write_1),
        .mem_to_reg(mem_to_reg_1), .reg_dest(reg_dest_1), .alu_src_a(alu_src_a_1),
        .alu_src_b(alu_src_b_1), .alu_op(alu_op_1), .pc_source(pc_source_1),
        .state_dbg(state_dbg_1)
    );

    control_unit #(.MEM_WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .reset(rst0), .opcode(opcode), .funct(funct), .zero(zero),
        .overflow(overflow), .pc_write(pc_write_0), .i_or_d(i_or_d_0),
        .mem_write(mem_write_0), .ir_write(ir_write_0), .reg_write(reg_write_0),
        .mem_to_reg(mem_to_reg_0), .reg_dest(reg_dest_0), .alu_src_a(alu_src_a_0),
        .alu_src_b(alu_src_b_0), .alu_op(alu_op_0), .pc_source(pc_source_0),
        .state_dbg(state_dbg_0)
    );

    assign act1 = {pc_write_1, i_or_d_1, mem_write_1, ir_write_1, reg_write_1, mem_to_reg_1,
                   reg_dest_1, alu_src_a_1, alu_src_b_1, alu_op_1, pc_source_1, state_dbg_1};
    assign act0 = {pc_write_0, i_or_d_0, mem_write_0, ir_write_0, reg_write_0, mem_to_reg_0,
                   reg_dest_0, alu_src_a_0, alu_src_b_0, alu_op_0, pc_source_0, state_dbg_0};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic ctl_t blank(input state_e s);
        ctl_t e;
        e    = '0;
        e.st = s;
        return e;
    endfunction

    function automatic logic [2:0] alu_of(input logic [5:0] fn);
        case (fn)
            6'h20:   return ALU_ADD;
            6'h22:   return ALU_SUB;
            6'h24:   return ALU_AND;
            6'h25:   return ALU_OR;
            6'h2A:   return ALU_SLT;
            default: return ALU_ADD;
        endcase
    endfunction

    task automatic push(input bit sel, inout int c, input ctl_t e, input string nm);
        entry_t x;
        c++;
        x.sel  = sel;
        x.cyc  = c;
        x.name = $sformatf("%s_c%0d", nm, c);
        x.exp  = e;
        exp_q.push_back(x);
    endtask

    // Expected cycle-by-cycle outputs of one instruction, from FETCH to the return to FETCH.
    task automatic build(input bit sel, input int mw, input logic [5:0] op, input logic [5:0] fn,
                         input logic z, input logic ov, input string nm, output int n);
        ctl_t e;
        int   c;
        bit   trap, known, ov_eff;
        c    = 0;
        trap = 0;
        for (int i = 0; i <= mw; i++) begin
            e = blank(StFetch); e.alu_src_b = 2'b01; e.alu_op = ALU_ADD;
            e.ir_write = (i == mw); e.pc_write = (i == mw);
            push(sel, c, e, nm);
        end
        e = blank(StDecode); e.alu_src_b = 2'b11; e.alu_op = ALU_ADD;
        push(sel, c, e, nm);
        case (op)
            6'h00: begin
                known = (fn == 6'h20) || (fn == 6'h22) || (fn == 6'h24) ||
                        (fn == 6'h25) || (fn == 6'h2A);
                e = blank(StExecR); e.alu_src_a = 1'b1; e.alu_op = alu_of(fn);
                push(sel, c, e, nm);
                if (!known) begin
                    trap = 1;
                end else begin
                    ov_eff = ov && ((fn == 6'h20) || (fn == 6'h22));
                    e = blank(StWbR); e.reg_dest = 1'b1; e.reg_write = !ov_eff;
                    push(sel, c, e, nm);
                    trap = ov_eff;
                end
            end
            6'h08: begin
                e = blank(StExecI); e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; e.alu_op = ALU_ADD;
                push(sel, c, e, nm);
                e = blank(StWbI); e.reg_write = !ov;
                push(sel, c, e, nm);
                trap = ov;
            end
            6'h23, 6'h2B: begin
                e = blank(StAddr); e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; e.alu_op = ALU_ADD;
                push(sel, c, e, nm);
                if (op == 6'h23) begin
                    for (int i = 0; i <= mw; i++) begin
                        e = blank(StMemRd); e.i_or_d = 1'b1;
                        push(sel, c, e, nm);
                    end
                    e = blank(StWbMem); e.mem_to_reg = 1'b1; e.reg_write = 1'b1;
                    push(sel, c, e, nm);
                end else begin
                    e = blank(StMemWr); e.i_or_d = 1'b1; e.mem_write = 1'b1;
                    push(sel, c, e, nm);
                end
            end
            6'h04, 6'h05: begin
                e = blank(StBranch); e.alu_src_a = 1'b1; e.alu_op = ALU_SUB; e.pc_source = 2'b01;
                e.pc_write = (op == 6'h04) ? z : !z;
                push(sel, c, e, nm);
            end
            6'h02: begin
                e = blank(StJump); e.pc_source = 2'b10; e.pc_write = 1'b1;
                push(sel, c, e, nm);
            end
            default: trap = 1;
        endcase
        if (trap) begin
            e = blank(StExcp); e.pc_source = 2'b11; e.pc_write = 1'b1;
            push(sel, c, e, nm);
        end
        n = c;
    endtask

    // Called one step after the edge that enters FETCH; returns at the same point of the next.
    task automatic run(input bit sel, input logic [5:0] op, input logic [5:0] fn,
                       input logic z, input logic ov, input string nm, output int n);
        opcode   = op;
        funct    = fn;
        zero     = z;
        overflow = ov;
        build(sel, sel ? 1 : 0, op, fn, z, ov, nm, n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Single compare process: one expected entry per cycle, sampled mid-cycle.
    always @(negedge clk) begin
        entry_t x;
        ctl_t   a;
        if (exp_q.size() != 0) begin
            x = exp_q.pop_front();
            a = x.sel ? act1 : act0;
            obs[x.cyc] = a;
            chk(x.name, a, x.exp);
        end
    end

    logic [5:0] fns[5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};

    initial begin
        int n;
        int dummy;
        entry_t r;
        rst1 = 1'b0; rst0 = 1'b0;
        opcode = 6'h00; funct = 6'h20; zero = 1'b0; overflow = 1'b0;
        dummy = 0;

        @(posedge clk); #1;
        push(1'b1, dummy, blank(StReset), "reset1");
        dummy = 0;
        push(1'b0, dummy, blank(StReset), "reset0");
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst1 = 1'b1;
        @(posedge clk); #1;

        run(1, OP_RTYPE, FN_ADD, 0, 0, "r_add", n);
        chk("r_add_len", n, 5);
        chk("r_add_c2_fetch_wr", {obs[2].ir_write, obs[2].pc_write}, 2'b11);
        chk("r_add_c1_no_wr", {obs[1].ir_write, obs[1].pc_write}, 2'b00);
        chk("r_add_c5_wb", {obs[5].reg_write, obs[5].reg_dest}, 2'b11);

        for (int i = 1; i < 5; i++) run(1, OP_RTYPE, fns[i], 0, 0, "r_fn", n);
        run(1, OP_ADDI, 6'h00, 0, 0, "addi", n);
        run(1, OP_ADDI, 6'h00, 0, 1, "addi_ov", n);
        chk("addi_ov_len", n, 6);

        run(1, OP_LW, 6'h00, 0, 0, "lw", n);
        chk("lw_len", n, 7);
        chk("lw_c5c6_iord", {obs[5].i_or_d, obs[6].i_or_d}, 2'b11);
        chk("lw_c7_wb", {obs[7].reg_write, obs[7].mem_to_reg}, 2'b11);

        run(1, OP_SW, 6'h00, 0, 0, "sw", n);
        chk("sw_len", n, 5);
        chk("sw_memwr_only_c5", {obs[1].mem_write, obs[2].mem_write, obs[3].mem_write,
                                 obs[4].mem_write, obs[5].mem_write}, 5'b00001);

        run(1, OP_BEQ, 6'h00, 1, 0, "beq_z1", n);
        chk("beq_z1_c4", {obs[4].pc_write, obs[4].pc_source}, 3'b101);
        run(1, OP_BEQ, 6'h00, 0, 0, "beq_z0", n);
        chk("beq_z0_c4", obs[4].pc_write, 1'b0);
        run(1, OP_BNE, 6'h00, 1, 0, "bne_z1", n);
        chk("bne_z1_c4", obs[4].pc_write, 1'b0);
        run(1, OP_BNE, 6'h00, 0, 0, "bne_z0", n);
        chk("bne_z0_c4", {obs[4].pc_write, obs[4].pc_source}, 3'b101);

        run(1, OP_J, 6'h00, 0, 0, "jump", n);
        chk("jump_c4_pcsrc", {obs[4].pc_write, obs[4].pc_source}, 3'b110);

        run(1, 6'h3F, 6'h00, 0, 0, "bad_op", n);
        chk("bad_op_len", n, 4);
        chk("bad_op_c4", {obs[4].pc_source, obs[4].pc_write, obs[4].reg_write}, 4'b1110);

        run(1, OP_RTYPE, FN_ADD, 0, 1, "r_add_ov", n);
        chk("r_add_ov_len", n, 6);
        chk("r_add_ov_c5_rw", obs[5].reg_write, 1'b0);
        chk("r_add_ov_c6", {obs[6].pc_source, obs[6].pc_write}, 3'b111);
        run(1, OP_RTYPE, FN_SUB, 0, 1, "r_sub_ov", n);
        run(1, OP_RTYPE, 6'h00, 0, 0, "r_bad_fn", n);

        // Reset asserted mid-MEM_RD of a lw: outputs drop at once, no write-back follows.
        opcode = OP_LW; funct = 6'h00; zero = 1'b0; overflow = 1'b0;
        build(1, 1, OP_LW, 6'h00, 0, 0, "lw_rst", n);
        void'(exp_q.pop_back());
        void'(exp_q.pop_back());
        repeat (4) @(posedge clk);
        @(negedge clk); #1;
        chk("lw_rst_in_memrd", state_dbg_1, 32'(StMemRd));
        rst1 = 1'b0;
        #1;
        chk("rst_async_outputs", act1, blank(StReset));
        r.sel = 1'b1; r.cyc = 1; r.name = "rst_next_cycle"; r.exp = blank(StReset);
        exp_q.push_back(r);
        @(posedge clk); #1;
        rst1 = 1'b1;
        @(posedge clk); #1;
        run(1, OP_RTYPE, FN_OR, 0, 0, "after_rst", n);

        // Zero-wait variant.
        rst1 = 1'b0;
        rst0 = 1'b1;
        @(posedge clk); #1;
        run(0, OP_RTYPE, FN_ADD, 0, 0, "mw0_r_add", n);
        chk("mw0_r_add_len", n, 4);
        chk("mw0_r_add_c4_wb", {obs[4].reg_write, obs[4].reg_dest}, 2'b11);
        run(0, OP_LW, 6'h00, 0, 0, "mw0_lw", n);
        chk("mw0_lw_len", n, 5);
        chk("mw0_back_to_fetch", state_dbg_0, 32'(StFetch));

        @(negedge clk); #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
